// File: rtl/lockin_pkg.sv
// Shared widths, delay-line geometry and sample/product types for the lock-in mixer.
package lockin_pkg;

  localparam int unsigned AdcWDefault = 14;
  localparam int unsigned RefWDefault = 14;
  localparam int unsigned OutWDefault = 28;

  // Reference delay line: tap 0 is the live input, taps 1..15 are registered stages.
  localparam int unsigned DelayDepth = 16;
  localparam int unsigned DelaySelW  = $clog2(DelayDepth);

  typedef logic signed [AdcWDefault-1:0]             adc_sample_t;
  typedef logic signed [RefWDefault-1:0]             ref_sample_t;
  typedef logic signed [AdcWDefault+RefWDefault-1:0] product_t;

endpackage

// File: rtl/ref_delay_line.sv
// Free-running reference shift register with a selectable alignment tap.
module ref_delay_line
  import lockin_pkg::*;
#(
  parameter int unsigned Width = RefWDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [Width-1:0]     din,
  input  logic [DelaySelW-1:0] sel,
  output logic [Width-1:0]     tap
);

  logic [Width-1:0] line_q [DelayDepth-1];
  logic [Width-1:0] taps   [DelayDepth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DelayDepth) - 1; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      line_q[0] <= din;
      for (int i = 1; i < int'(DelayDepth) - 1; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  // sel = 0 bypasses the registers so the caller samples the current input.
  always_comb begin
    taps[0] = din;
    for (int i = 1; i < int'(DelayDepth); i++) begin
      taps[i] = line_q[i-1];
    end
  end

  assign tap = taps[sel];

endmodule

// File: rtl/lockin_mixer.sv
// Lock-in mixer: ADC sample times aligned DDS reference, three-stage pipeline.
// Define MIXER_DECIM_EN to add accumulate-and-dump decimation after the product stage.
module lockin_mixer
  import lockin_pkg::*;
#(
  parameter int unsigned ADC_W      = AdcWDefault,
  parameter int unsigned REF_W      = RefWDefault,
  parameter int unsigned OUT_W      = OutWDefault,
  parameter int unsigned DECIM_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ADC_W-1:0] adc_in,
  input  logic             adc_valid,
  input  logic [REF_W-1:0] sine,
  input  logic [3:0]       ref_delay,
  output logic [OUT_W-1:0] signal_out,
  output logic             out_valid
);

  localparam int unsigned ProdW = ADC_W + REF_W;

  logic [REF_W-1:0] ref_aligned;

  ref_delay_line #(
    .Width(REF_W)
  ) u_ref_delay_line (
    .clk  (clk),
    .reset(reset),
    .din  (sine),
    .sel  (ref_delay),
    .tap  (ref_aligned)
  );

  logic signed [ADC_W-1:0] adc_q;
  logic signed [REF_W-1:0] ref_q;
  logic                    v1_q;
  logic signed [ProdW-1:0] prod_d;
  logic signed [ProdW-1:0] prod_q;
  logic                    v2_q;
  logic signed [OUT_W-1:0] prod_ext;

  always_comb begin
    prod_d = ProdW'(adc_q) * ProdW'(ref_q);
  end

  // Dropping enable kills every in-flight valid on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_q  <= '0;
      ref_q  <= '0;
      v1_q   <= 1'b0;
      prod_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      v1_q <= adc_valid & enable;
      v2_q <= v1_q & enable;
      if (adc_valid && enable) begin
        adc_q <= adc_in;
        ref_q <= ref_aligned;
      end
      if (v1_q && enable) begin
        prod_q <= prod_d;
      end
    end
  end

  if (OUT_W >= ProdW) begin : g_ext
    assign prod_ext = OUT_W'(prod_q);
  end else begin : g_trunc
    assign prod_ext = prod_q[OUT_W-1:0];
  end

`ifdef MIXER_DECIM_EN
  localparam int unsigned AccW = OUT_W + DECIM_LOG2;

  logic signed [OUT_W-1:0]      ext_q;
  logic                         v3_q;
  logic signed [AccW-1:0]       acc_q;
  logic signed [AccW-1:0]       acc_sum;
  logic signed [AccW-1:0]       acc_shr;
  logic        [DECIM_LOG2-1:0] cnt_q;

  always_comb begin
    acc_sum = acc_q + AccW'(ext_q);
    acc_shr = acc_sum >>> DECIM_LOG2;
  end

  // The dumping product is folded into the output; the accumulator restarts empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q      <= '0;
      v3_q       <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      signal_out <= '0;
      out_valid  <= 1'b0;
    end else if (!enable) begin
      v3_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      v3_q      <= v2_q;
      out_valid <= 1'b0;
      if (v2_q) begin
        ext_q <= prod_ext;
      end
      if (v3_q) begin
        if (cnt_q == '1) begin
          signal_out <= acc_shr[OUT_W-1:0];
          out_valid  <= 1'b1;
          acc_q      <= '0;
          cnt_q      <= '0;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + DECIM_LOG2'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signal_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= v2_q & enable;
      if (v2_q && enable) begin
        signal_out <= prod_ext;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lockin_mixer.sv
// Directed self-checking bench for lockin_mixer (default build; MIXER_DECIM_EN adds a decimation case).
module tb_lockin_mixer;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [13:0] adc_in;
  logic               adc_valid;
  logic signed [13:0] sine;
  logic [3:0]         ref_delay;
  logic signed [27:0] signal_out;
  logic               out_valid;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  lockin_mixer #(
    .ADC_W     (14),
    .REF_W     (14),
    .OUT_W     (28),
    .DECIM_LOG2(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .adc_in    (adc_in),
    .adc_valid (adc_valid),
    .sine      (sine),
    .ref_delay (ref_delay),
    .signal_out(signal_out),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_in = '0; sine = '0; ref_delay = '0;
    repeat (2) tick();
    check("rst_signal", signal_out, 0);
    check("rst_valid", out_valid, 0);
    reset  = 1'b0;
    enable = 1'b1;
    tick();

`ifndef MIXER_DECIM_EN
    // Max positive product, single sample in cycle 0.
    sine = 14'sd8191; adc_in = 14'sd8191; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("pos_valid_c%0d", c), out_valid, (c == 3));
      if (c >= 3) check($sformatf("pos_value_c%0d", c), signal_out, 67092481);
      tick();
    end

    // Most negative squared must come out positive.
    sine = -14'sd8192; adc_in = -14'sd8192; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    repeat (2) tick();
    check("neg_valid", out_valid, 1);
    check("neg_value", signal_out, 67108864);
    tick();
    check("hold_valid", out_valid, 0);
    check("hold_value", signal_out, 67108864);

    // Back-to-back samples give one result per cycle.
    sine = 14'sd10;
    for (int i = 0; i < 7; i++) begin
      adc_valid = (i < 3);
      adc_in    = 14'(i + 1);
      if (i >= 3 && i < 6) begin
        check($sformatf("b2b_valid_c%0d", i), out_valid, 1);
        check($sformatf("b2b_value_c%0d", i), signal_out, (i - 2) * 10);
      end
      if (i == 6) check("b2b_bubble", out_valid, 0);
      tick();
    end

    // Reference alignment: 1000 in cycle 4 only, ref_delay 5, so 2000 only at cycle 12.
    sine = '0; adc_valid = 1'b0; ref_delay = 4'd5;
    repeat (16) tick();
    adc_in = 14'sd2;
    for (int j = 0; j < 18; j++) begin
      sine      = (j == 4) ? 14'sd1000 : 14'sd0;
      adc_valid = 1'b1;
      if (j >= 3) check($sformatf("dly_value_c%0d", j), signal_out, (j == 12) ? 2000 : 0);
      tick();
    end
    check("dly_valid", out_valid, 1);

    // Enable drops at cycle 6 with adc_valid still high.
    sine = 14'sd7; ref_delay = 4'd0;
    for (int j = 0; j < 10; j++) begin
      adc_in    = 14'(j + 1);
      adc_valid = 1'b1;
      enable    = (j < 6);
      if (j >= 3 && j <= 6) begin
        check($sformatf("en_valid_c%0d", j), out_valid, 1);
        check($sformatf("en_value_c%0d", j), signal_out, (j - 2) * 7);
      end else if (j > 6) begin
        check($sformatf("en_off_valid_c%0d", j), out_valid, 0);
        check($sformatf("en_off_value_c%0d", j), signal_out, 28);
      end
      tick();
    end

    // Re-enable: first accepted sample at cycle 0 comes out at cycle 3.
    enable = 1'b1; adc_in = 14'sd50; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("reen_valid_c%0d", c), out_valid, (c == 3));
      if (c < 3) tick();
    end
    check("reen_value", signal_out, 350);

    // Reset mid-stream while results are flowing.
    sine = 14'sd5; adc_in = 14'sd5; adc_valid = 1'b1;
    repeat (4) tick();
    check("mid_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_signal", signal_out, 0);
    check("mid_rst_valid", out_valid, 0);
    tick();
    reset = 1'b0; sine = 14'sd50; ref_delay = 4'd3; adc_in = 14'sd1; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("post_rst_valid_c%0d", c), out_valid, (c == 3));
      if (c == 3) check("post_rst_empty_line", signal_out, 0);
      tick();
    end
    // Line now refilled with 50.
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    repeat (2) tick();
    check("refill_valid", out_valid, 1);
    check("refill_value", signal_out, 50);
`else
    // Products 100, 200, 300, 401 average to floor(1001/4) = 250, four cycles after the last.
    sine = 14'sd1;
    for (int i = 0; i < 4; i++) begin
      adc_in    = (i == 0) ? 14'sd100 : (i == 1) ? 14'sd200 : (i == 2) ? 14'sd300 : 14'sd401;
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      check($sformatf("dec_valid_c%0d", c), out_valid, (c == 7));
      if (c >= 7) check($sformatf("dec_value_c%0d", c), signal_out, 250);
      tick();
    end

    // Partial block is discarded by enable low.
    adc_in = 14'sd1000; adc_valid = 1'b1;
    repeat (2) tick();
    adc_valid = 1'b0; enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1; adc_in = 14'sd40; adc_valid = 1'b1;
    repeat (4) tick();
    adc_valid = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      check($sformatf("part_valid_c%0d", c), out_valid, (c == 7));
      if (c >= 7) check($sformatf("part_value_c%0d", c), signal_out, 40);
      tick();
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
